// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq: registered one-hot decoder behind a single valid/ready slot.
// Define DEC_SCAN_EN to add the rotating scan mode (idx counter, mode-edge detect).
module dec_onehot_seq #(
    parameter int N    = 3,
    parameter int OUTS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in,
    input  logic            mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OUTS-1:0] out,
    output logic            err
);

    localparam logic [N:0] LP_OUTS = (N+1)'(OUTS);

    logic            r_valid;
    logic            r_err;
    logic [OUTS-1:0] r_out;

    logic            w_free;
    logic            w_in_rng;
    logic            w_dec_load;
    logic            w_scan_load;
    logic [OUTS-1:0] w_dec_hot;
    logic [OUTS-1:0] w_scan_hot;
    logic            w_nxt_valid;
    logic            w_nxt_err;
    logic [OUTS-1:0] w_nxt_out;

    assign w_free   = !r_valid || out_ready;
    assign w_in_rng = ({1'b0, in} < LP_OUTS);

    // Out-of-range codes match no bit, so the pattern is naturally all-zero.
    always_comb begin
        w_dec_hot = '0;
        for (int i = 0; i < OUTS; i++)
            w_dec_hot[i] = ({1'b0, in} == (N+1)'(i));
    end

`ifdef DEC_SCAN_EN
    logic [N-1:0] r_idx;
    logic         r_prev_mode;
    logic [N-1:0] w_idx_eff;
    logic [N-1:0] w_idx_nxt;

    // A rising mode edge restarts the scan even if the slot is stalled.
    assign w_idx_eff   = (mode && !r_prev_mode) ? '0 : r_idx;
    assign w_scan_load = mode && w_free;
    assign in_ready    = w_free && !mode;

    always_comb begin
        w_scan_hot = '0;
        for (int i = 0; i < OUTS; i++)
            w_scan_hot[i] = (w_idx_eff == N'(i));
    end

    always_comb begin
        w_idx_nxt = w_idx_eff;
        if (w_scan_load)
            w_idx_nxt = (w_idx_eff == N'(OUTS-1)) ? '0 : w_idx_eff + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_prev_mode <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_prev_mode <= mode;
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;
    assign w_scan_load   = 1'b0;
    assign w_scan_hot    = '0;
    assign in_ready      = w_free;
`endif

    assign w_dec_load = in_valid && in_ready;

    always_comb begin
        w_nxt_valid = r_valid;
        w_nxt_err   = r_err;
        w_nxt_out   = r_out;
        if (w_scan_load) begin
            w_nxt_valid = 1'b1;
            w_nxt_err   = 1'b0;
            w_nxt_out   = w_scan_hot;
        end else if (w_dec_load) begin
            w_nxt_valid = 1'b1;
            w_nxt_err   = !w_in_rng;
            w_nxt_out   = w_dec_hot;
        end else if (w_free) begin
            w_nxt_valid = 1'b0;
            w_nxt_err   = 1'b0;
            w_nxt_out   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_out   <= '0;
        end else begin
            r_valid <= w_nxt_valid;
            r_err   <= w_nxt_err;
            r_out   <= w_nxt_out;
        end
    end

    assign out_valid = r_valid;
    assign err       = r_err;
    assign out       = r_out;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Bench for dec_onehot_seq: OUTS=8 and OUTS=6 instances share one stimulus stream.
// Vector table, directed stall/back-to-back/reset sequences, then random vs model.
module tb_dec_onehot_seq;

`ifdef DEC_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_c;
    logic       mode;
    logic       out_ready;
    logic       rdy8, rdy6, v8, v6, e8, e6;
    logic [7:0] o8;
    logic [5:0] o6;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dec_onehot_seq #(.N(3), .OUTS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
        .in(in_c), .mode(mode), .out_valid(v8), .out_ready(out_ready),
        .out(o8), .err(e8)
    );

    dec_onehot_seq #(.N(3), .OUTS(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6),
        .in(in_c), .mode(mode), .out_valid(v6), .out_ready(out_ready),
        .out(o6), .err(e6)
    );

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic       r;
        logic       rdy;
        logic [7:0] o8;
        logic       ov;
        logic       e8;
        logic [5:0] o6;
        logic       e6;
    } vec_t;

    vec_t tab[10];

    // Reference model state: index 0 -> OUTS=8, index 1 -> OUTS=6.
    logic       m_valid[2];
    logic [7:0] m_pat[2];
    logic       m_err[2];
    int         m_idx[2];
    logic       m_prev;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] x8,
                           input logic xv, input logic x8e,
                           input logic [5:0] x6, input logic x6e);
        chk({nm, "_o8"}, 32'(o8), 32'(x8));
        chk({nm, "_v8"}, 32'(v8), 32'(xv));
        chk({nm, "_e8"}, 32'(e8), 32'(x8e));
        chk({nm, "_o6"}, 32'(o6), 32'(x6));
        chk({nm, "_v6"}, 32'(v6), 32'(xv));
        chk({nm, "_e6"}, 32'(e6), 32'(x6e));
    endtask

    task automatic drive(input logic v, input logic [2:0] c,
                         input logic m, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_c      = c;
        mode      = m;
        out_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_pat[k]   = '0;
            m_err[k]   = 1'b0;
            m_idx[k]   = 0;
        end
        m_prev = 1'b0;
    endtask

    function automatic logic model_rdy(input logic m, input logic r);
        return (!m_valid[0] || r) && !(SCAN && m);
    endfunction

    task automatic model_step(input logic v, input int c,
                              input logic m, input logic r);
        int outs;
        logic free;
        for (int k = 0; k < 2; k++) begin
            outs = (k == 0) ? 8 : 6;
            free = !m_valid[k] || r;
            if (SCAN && m && !m_prev)
                m_idx[k] = 0;
            if (SCAN && m && free) begin
                m_pat[k]   = 8'(1 << m_idx[k]);
                m_err[k]   = 1'b0;
                m_valid[k] = 1'b1;
                m_idx[k]   = (m_idx[k] + 1) % outs;
            end else if (!(SCAN && m) && v && free) begin
                m_pat[k]   = (c < outs) ? 8'(1 << c) : 8'h00;
                m_err[k]   = (c >= outs);
                m_valid[k] = 1'b1;
            end else if (free) begin
                m_pat[k]   = '0;
                m_err[k]   = 1'b0;
                m_valid[k] = 1'b0;
            end
        end
        m_prev = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_c      = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] x8;
        logic [5:0] x6;
        logic       v, m, r;
        int         c;

        tab[0] = '{1'b1, 3'd5, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 6'h20, 1'b0};
        tab[1] = '{1'b1, 3'd7, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 6'h00, 1'b1};
        tab[2] = '{1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'h00, 1'b0};
        tab[3] = '{1'b1, 3'd6, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 6'h00, 1'b1};
        tab[4] = '{1'b1, 3'd1, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 6'h00, 1'b1};
        tab[5] = '{1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'h00, 1'b0};
        tab[6] = '{1'b1, 3'd0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 6'h01, 1'b0};
        tab[7] = '{1'b1, 3'd2, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 6'h04, 1'b0};
        tab[8] = '{1'b0, 3'd3, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 6'h04, 1'b0};
        tab[9] = '{1'b0, 3'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'h00, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_c      = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        chk("reset_rdy8", 32'(rdy8), 32'd1);
        chk("reset_rdy6", 32'(rdy6), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(tab[i].v, tab[i].c, 1'b0, tab[i].r);
            chk($sformatf("tab%0d_rdy8", i), 32'(rdy8), 32'(tab[i].rdy));
            chk($sformatf("tab%0d_rdy6", i), 32'(rdy6), 32'(tab[i].rdy));
            tick();
            chk_all($sformatf("tab%0d", i), tab[i].o8, tab[i].ov, tab[i].e8,
                    tab[i].o6, tab[i].e6);
        end

        drive(1'b1, 3'd2, 1'b0, 1'b1);
        tick();
        chk_all("stall_load", 8'h04, 1'b1, 1'b0, 6'h04, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd6, 1'b0, 1'b0);
            chk($sformatf("stall%0d_rdy", i), 32'(rdy8), 32'd0);
            tick();
            chk_all($sformatf("stall%0d", i), 8'h04, 1'b1, 1'b0, 6'h04, 1'b0);
        end
        drive(1'b1, 3'd6, 1'b0, 1'b1);
        chk("stall_rel_rdy", 32'(rdy8), 32'd1);
        tick();
        chk_all("stall_rel", 8'h40, 1'b1, 1'b0, 6'h00, 1'b1);

        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), 1'b0, 1'b1);
            tick();
            x8 = 8'(1 << k);
            x6 = (k < 6) ? 6'(1 << k) : 6'h00;
            chk_all($sformatf("b2b%0d", k), x8, 1'b1, 1'b0, x6, (k >= 6));
        end
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        chk_all("b2b_drain", 8'h00, 1'b0, 1'b0, 6'h00, 1'b0);

        drive(1'b1, 3'd3, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd4, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("arst_now", 8'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        chk("arst_rdy", 32'(rdy8), 32'd1);
        tick();
        chk_all("arst_edge", 8'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_c      = 3'd3;
        out_ready = 1'b1;
        #1;
        chk_all("arst_rel", 8'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        tick();
        chk_all("arst_first", 8'h08, 1'b1, 1'b0, 6'h08, 1'b0);

`ifdef DEC_SCAN_EN
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'd1, 1'b1, 1'b1);
            chk($sformatf("scan%0d_rdy", k), 32'(rdy8), 32'd0);
            tick();
            chk_all($sformatf("scan%0d", k), 8'(1 << k), 1'b1, 1'b0,
                    6'(1 << (k % 6)), 1'b0);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        chk_all("scan_hold", 8'h80, 1'b1, 1'b0, 6'h02, 1'b0);
        drive(1'b0, 3'd0, 1'b1, 1'b1);
        tick();
        chk_all("scan_restart", 8'h01, 1'b1, 1'b0, 6'h01, 1'b0);
        drive(1'b0, 3'd0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("scan_arst", 8'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all("scan_after_rst", 8'h01, 1'b1, 1'b0, 6'h01, 1'b0);
`endif

        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            c = int'($urandom_range(0, 7));
            m = 1'($urandom_range(0, 4) == 0);
            r = 1'($urandom_range(0, 2) != 0);
            drive(v, 3'(c), m, r);
            chk("rnd_rdy8", 32'(rdy8), 32'(model_rdy(m, r)));
            chk("rnd_rdy6", 32'(rdy6), 32'(model_rdy(m, r)));
            model_step(v, c, m, r);
            tick();
            chk_all("rnd", m_pat[0], m_valid[0], m_err[0],
                    m_pat[1][5:0], m_err[1]);
            chk("rnd_v6", 32'(v6), 32'(m_valid[1]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_onehot_seq.md
DEC_ONEHOT_SEQ -- requirements
Module: dec_onehot_seq

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning select-input width in bits (1..6).
REQ-002 The block SHALL have parameter OUTS, default 8, meaning number of one-hot outputs (2..2^N).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: the select code on in is valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts a code this cycle.
REQ-007 Port in, input, N bits: the select code.
REQ-008 Port mode, input, 1 bit: 0 = decode, 1 = scan.
REQ-009 Port out_valid, output, 1 bit: out holds a valid pattern.
REQ-010 Port out_ready, input, 1 bit: the downstream consumes out this cycle.
REQ-011 Port out, output, OUTS bits: the registered one-hot pattern.
REQ-012 Port err, output, 1 bit: the held pattern came from an out-of-range code.

Function
REQ-013 The output stage SHALL be a single registered entry, with in_ready = !out_valid || out_ready (combinational).
REQ-014 In decode mode, an input transfer SHALL occur when in_valid && in_ready.
REQ-015 On a decode transfer, out SHALL load 1<<in when in < OUTS, and out_valid SHALL be set to 1 on the next edge (latency 1 cycle).
REQ-016 On a decode transfer with in >= OUTS, out SHALL load all-zero, err SHALL be set to 1, and out_valid SHALL be set to 1.
REQ-017 For an in-range transfer, err SHALL be set to 0.
REQ-018 While out_valid && !out_ready, out, err and out_valid SHALL hold unchanged; in and in_valid SHALL be ignored.
REQ-019 When out_valid && out_ready with no new load, out_valid SHALL clear, out SHALL clear to 0, and err SHALL clear to 0.
REQ-020 When a consume and a new load happen in the same cycle, the new pattern SHALL be loaded with out_valid staying 1, giving full throughput of one pattern per cycle.
REQ-021 In scan mode, in_ready SHALL be 0 and in/in_valid SHALL be ignored.
REQ-022 In scan mode, whenever !out_valid || out_ready, out SHALL load 1<<idx, out_valid SHALL be set to 1, err SHALL be set to 0, and idx SHALL increment.
REQ-023 In scan mode, idx SHALL wrap from OUTS-1 to 0, including when OUTS < 2^N.
REQ-024 idx SHALL reset to 0 on each mode 0->1 transition, so the first scan pattern is always bit 0.
REQ-025 A mode change while out_valid && !out_ready SHALL NOT alter the held pattern; the new mode applies from the next load opportunity.
REQ-026 out SHALL always be one-hot or all-zero; more than one set bit is forbidden.

Reset
REQ-027 When rst_n is low, out = 0, out_valid = 0, err = 0, idx = 0 and the recorded previous mode = 0 SHALL apply immediately, without waiting for clk.
REQ-028 in_ready SHALL read 1 while in reset, following from REQ-013.
REQ-029 Reset asserted mid-stall or mid-scan SHALL discard the held pattern, with no output transfer.
REQ-030 After rst_n deasserts, the first load SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-031 Macro DEC_SCAN_EN defined: the scan mode, idx counter and mode-edge detection SHALL be present per REQ-021 to REQ-024.
REQ-032 Macro DEC_SCAN_EN undefined: the mode port SHALL remain present but be ignored (the block always decodes), and no idx state SHALL be implemented.

Verification
REQ-033 N=3, OUTS=8: in=5 with in_valid, out_ready=1 -> next cycle out=8'b0010_0000, out_valid=1, err=0.
REQ-034 N=3, OUTS=6: in=7 -> out=0, err=1, out_valid=1; after out_ready -> out_valid=0, err=0.
REQ-035 Stall test: load in=2, hold out_ready=0 for 4 cycles while presenting in=6 -> out stays 8'b0000_0100 and in_ready=0; then out_ready=1 -> next cycle out=8'b0100_0000.
REQ-036 Back-to-back test: in_valid=1 and out_ready=1 continuously with codes 0..7 -> eight consecutive valid one-hot patterns, no bubbles.
REQ-037 DEC_SCAN_EN, OUTS=6, mode=1, out_ready=1 -> out sequence 1,2,4,8,16,32,1,...; set out_ready=0 mid-scan -> pattern held; toggle mode 1->0->1 -> scan restarts at bit 0.
REQ-038 Assert rst_n=0 asynchronously mid-scan between clock edges -> out=0 and out_valid=0 immediately; after release the first scan pattern is 1.
